// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit and the sign-extend stage.
// Holds the FSM state enum, instruction field positions, opcode / condition /
// extension-select codes and the packed datapath strobe bundle.
package mc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 24;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned EXT_W   = 2;
  localparam int unsigned STATE_W = 3;

  // Instruction field positions
  localparam int unsigned COND_LSB = 28;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned I_BIT    = 25;
  localparam int unsigned L_BIT    = 20;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_LS  = 2'b01;
  localparam logic [OP_W-1:0] OP_B   = 2'b10;
  localparam logic [OP_W-1:0] OP_UND = 2'b11;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;

  localparam logic [EXT_W-1:0] EXT_IMM8  = 2'b00;
  localparam logic [EXT_W-1:0] EXT_IMM12 = 2'b01;
  localparam logic [EXT_W-1:0] EXT_IMM24 = 2'b10;
  localparam logic [EXT_W-1:0] EXT_ZERO  = 2'b11;

  // Datapath strobes produced each cycle by the control FSM
  typedef struct packed {
    logic imem_req;
    logic ir_we;
    logic pc_we;
    logic pc_src;
    logic alu_src_imm;
    logic dmem_rd;
    logic dmem_wr;
    logic reg_we;
    logic wb_sel;
    logic undef_instr;
  } ctrl_t;

  // Extension select for a given opcode
  function automatic logic [EXT_W-1:0] ext_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_DP:   return EXT_IMM8;
      OP_LS:   return EXT_IMM12;
      OP_B:    return EXT_IMM24;
      default: return EXT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// Control-unit bus: instruction/memory handshakes in, IR view and strobes out.
// master = control unit side, slave = datapath / memory side.
interface mc_if;
  import mc_pkg::*;

  logic [INSTR_W-1:0] instr_in;
  logic               imem_ready;
  logic               dmem_ready;
  logic               z_flag;

  logic [INSTR_W-1:0] ir;
  logic [IMM_W-1:0]   imm;
  logic [EXT_W-1:0]   Extop;
  logic               imem_req;
  logic               ir_we;
  logic               pc_we;
  logic               pc_src;
  logic               alu_src_imm;
  logic               dmem_rd;
  logic               dmem_wr;
  logic               reg_we;
  logic               wb_sel;
  logic               undef_instr;
  logic [STATE_W-1:0] state;

  modport master (
    input  instr_in, imem_ready, dmem_ready, z_flag,
    output ir, imm, Extop, imem_req, ir_we, pc_we, pc_src, alu_src_imm,
           dmem_rd, dmem_wr, reg_we, wb_sel, undef_instr, state
  );

  modport slave (
    output instr_in, imem_ready, dmem_ready, z_flag,
    input  ir, imm, Extop, imem_req, ir_we, pc_we, pc_src, alu_src_imm,
           dmem_rd, dmem_wr, reg_we, wb_sel, undef_instr, state
  );

endinterface

// File: rtl/cond_check.sv
// Condition-code evaluator.
// Ports: cond (4b condition field), z_flag (zero flag) -> pass (1 = execute).
module cond_check
  import mc_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic              z_flag,
  output logic              pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_flag;
      COND_NE: pass = ~z_flag;
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control unit: instruction register plus FETCH/DECODE/EXEC/MEM/WB
// sequencer with ready-based memory wait states.
// Ports: clk, rst (sync, active high), bus (mc_if.master: instr_in,
// imem_ready, dmem_ready, z_flag in; ir, imm, Extop, strobes, state out).
module mc_control
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mc_if.master bus
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  ctrl_t              ctrl;
  logic [OP_W-1:0]    op;
  logic               i_bit;
  logic               l_bit;
  logic               cond_pass;

  assign op    = ir_q[OP_LSB +: OP_W];
  assign i_bit = ir_q[I_BIT];
  assign l_bit = ir_q[L_BIT];

  cond_check u_cond_check (
    .cond   (ir_q[COND_LSB +: COND_W]),
    .z_flag (bus.z_flag),
    .pass   (cond_pass)
  );

  // State register and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign ir_d = ctrl.ir_we ? bus.instr_in : ir_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (bus.imem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        // Undefined opcode takes priority over the condition check
        if (op == OP_UND || !cond_pass) state_d = ST_FETCH;
        else                            state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op)
          OP_DP:   state_d = ST_WB;
          OP_LS:   state_d = ST_MEM;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM:    if (bus.dmem_ready) state_d = l_bit ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Strobe decode; reset masks everything in the same cycle it is high
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          ctrl.imem_req = 1'b1;
          ctrl.ir_we    = bus.imem_ready;
          ctrl.pc_we    = bus.imem_ready;
        end
        ST_DECODE: ctrl.undef_instr = (op == OP_UND);
        ST_EXEC: begin
          ctrl.alu_src_imm = (op == OP_DP) ? i_bit : (op == OP_LS);
          if (op == OP_B) begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = 1'b1;
          end
        end
        ST_MEM: begin
          ctrl.dmem_rd = l_bit;
          ctrl.dmem_wr = ~l_bit;
        end
        ST_WB: begin
          ctrl.reg_we = 1'b1;
          ctrl.wb_sel = (op == OP_LS) && l_bit;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.ir          = ir_q;
  assign bus.imm         = ir_q[IMM_W-1:0];
  assign bus.Extop       = ext_sel(op);
  assign bus.state       = state_q;
  assign bus.imem_req    = ctrl.imem_req;
  assign bus.ir_we       = ctrl.ir_we;
  assign bus.pc_we       = ctrl.pc_we;
  assign bus.pc_src      = ctrl.pc_src;
  assign bus.alu_src_imm = ctrl.alu_src_imm;
  assign bus.dmem_rd     = ctrl.dmem_rd;
  assign bus.dmem_wr     = ctrl.dmem_wr;
  assign bus.reg_we      = ctrl.reg_we;
  assign bus.wb_sel      = ctrl.wb_sel;
  assign bus.undef_instr = ctrl.undef_instr;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the CPU core. It holds the fetched instruction in the instruction register (IR) and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready-based memory wait states. It drives the immediate field and extension-select code that feed the sign-extension stage directly downstream, plus all datapath strobes.

## Interface
Parameters:
- none; all encodings are fixed constants in `mc_pkg`.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_in`  in  32  instruction word from instruction memory.
- `imem_ready`  in  1  `instr_in` is valid this cycle; sampled only in FETCH.
- `dmem_ready`  in  1  data access completes this cycle; sampled only in MEM.
- `z_flag`  in  1  zero flag from the datapath.
- `ir`  out  32  registered instruction.
- `imm`  out  24  `ir[23:0]`, to the sign-extend stage.
- `Extop`  out  2  extension select, to the sign-extend stage.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  IR load strobe.
- `pc_we`  out  1  PC write strobe.
- `pc_src`  out  1  PC source: 0 = PC+4, 1 = branch target.
- `alu_src_imm`  out  1  ALU operand B select: 1 = extended immediate.
- `dmem_rd`  out  1  data memory read.
- `dmem_wr`  out  1  data memory write.
- `reg_we`  out  1  register file write.
- `wb_sel`  out  1  writeback source: 0 = ALU, 1 = memory.
- `undef_instr`  out  1  one-cycle pulse on an undefined opcode.
- `state`  out  3  current FSM state, for debug.

## Operation
Encoding is fixed:
- `ir[31:28]` is the condition code:
  - 0000 EQ passes when `z_flag` = 1.
  - 0001 NE passes when `z_flag` = 0.
  - 1110 AL always passes.
  - Any other code never passes.
- `ir[27:26]` is the opcode:
  - 00 = data processing. `ir[25]` = I selects the immediate operand.
  - 01 = load/store. `ir[20]` = 1 is a load.
  - 10 = branch.
  - 11 = undefined.
- `Extop` is combinational from `ir[27:26]`: 00→00 (imm8), 01→01 (imm12), 10→10 (imm24 branch), 11→11 (extender outputs zero).
- `imm` = `ir[23:0]` at all times.

States and transitions:
- **FETCH**
  - `imem_req` = 1.
  - On `imem_ready`: `ir_we` = 1, `pc_we` = 1, `pc_src` = 0. Next state DECODE.
  - Otherwise stay in FETCH.
- **DECODE**: one cycle.
  - Opcode 11: pulse `undef_instr`, go to FETCH.
  - Condition fails: go to FETCH. No side effects.
  - Otherwise: go to EXEC.
- **EXEC**: one cycle.
  - `alu_src_imm` = `ir[25]` for data processing; = 1 for load/store.
  - Data processing goes to WB.
  - Load/store goes to MEM.
  - Branch: `pc_we` = 1, `pc_src` = 1, go to FETCH.
- **MEM**
  - `dmem_rd` = L and `dmem_wr` = !L, held until `dmem_ready`.
  - On `dmem_ready`: a load goes to WB, a store goes to FETCH.
- **WB**: one cycle.
  - `reg_we` = 1.
  - `wb_sel` = 1 for a load, 0 otherwise.
  - Go to FETCH.

Strobes not listed for a state are 0.

## Timing
- Reset:
  - While `rst` = 1, all strobes and `undef_instr` are 0, `ir` = 0 (so `imm` = 0 and `Extop` = 00), and the state is FETCH.
  - `imem_req` rises in the first cycle after `rst` falls.
- `rst` asserted mid-instruction:
  - Next state is FETCH.
  - Pending `dmem_rd`, `dmem_wr` or `imem_req` drop in the same cycle `rst` is high.
  - No `reg_we` or `pc_we` is issued.
- `ir` updates on the edge ending the FETCH cycle with `imem_ready` = 1. `imm` and `Extop` are valid from DECODE onward and stable until the next fetch completes.
- Cycles per instruction, with zero memory wait states:

| Instruction | Cycles |
|---|---|
| Data processing | 4 |
| Load | 5 |
| Store | 4 |
| Branch taken | 3 |
| Condition fail | 2 |
| Undefined | 2 |

- Each memory wait cycle adds one cycle.
- `imem_ready` outside FETCH and `dmem_ready` outside MEM are ignored.
- `z_flag` is sampled only in DECODE.

## Structure
- `mc_pkg` holds:
  - the state enum;
  - opcode constants (`OP_DP`, `OP_LS`, `OP_B`, `OP_UND`);
  - condition constants (`COND_EQ`, `COND_NE`, `COND_AL`);
  - `Extop` codes (`EXT_IMM8`, `EXT_IMM12`, `EXT_IMM24`).
- The sign-extend stage imports the same `Extop` codes from `mc_pkg`.
- One combinational sub-module, `cond_check` (inputs: cond, `z_flag`; output: pass).
- The FSM and IR stay in `mc_control`.

## Test plan
- **Reset:** `rst` held 3 cycles, then released → all strobes 0 during reset; `imem_req` = 1 in the next cycle; `state` = FETCH.
- **Immediate data processing:** fetch 0xE2000055 with `imem_ready` = 1 → `Extop` = 00 and `imm` = 0x000055 in DECODE; `alu_src_imm` = 1 in EXEC; `reg_we` = 1 in cycle 4; next fetch in cycle 5.
- **Load with waits:** LDR 0xE4100ABC with `dmem_ready` low for 2 cycles → `Extop` = 01, `imm` = 0x100ABC; `dmem_rd` high for exactly 3 cycles; `reg_we` = 1 with `wb_sel` = 1; total 7 cycles.
- **Conditional branch:** BEQ 0x0AFFFFFE.
  - `z_flag` = 1 → `Extop` = 10; `pc_we` = 1 with `pc_src` = 1 in cycle 3.
  - `z_flag` = 0 → back to FETCH after DECODE; no `pc_src` = 1.
- **Undefined and condition-fail:** 0xEC000000 → `undef_instr` pulses 1 cycle in DECODE; no `reg_we`, `dmem_rd`, `dmem_wr`. Cond 0101 → 2-cycle skip.
- **Reset mid-MEM:** store stalled with `dmem_ready` = 0, `rst` pulsed → `dmem_wr` = 0 in the reset cycle; FETCH afterwards; no `pc_we` from EXEC or MEM.
